// File: rtl/fifo_pop_packer_if.sv
// Interface between the fifo_v3 read port, the packer and the wide valid/ready sink.
// The master side is the packer; the slave side is the FIFO/sink environment.
interface fifo_pop_packer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RATIO = 4
);
  localparam int unsigned CNT_W = $clog2(RATIO + 1);

  logic                   flush_i;
  logic                   empty_i;
  logic [WIDTH-1:0]       data_i;
  logic                   pop_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [WIDTH*RATIO-1:0] data_o;
  logic [CNT_W-1:0]       count_o;

  modport master (
    input  flush_i, empty_i, data_i, ready_i,
    output pop_o, valid_o, data_o, count_o
  );

  modport slave (
    output flush_i, empty_i, data_i, ready_i,
    input  pop_o, valid_o, data_o, count_o
  );
endinterface

// File: rtl/fifo_pop_packer.sv
// Pops narrow fifo_v3 words and packs RATIO of them into one wide valid/ready beat;
// a flush emits the partially filled beat with its lane count.
module fifo_pop_packer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RATIO = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fifo_pop_packer_if.master bus
);
  localparam int unsigned       CNT_W = $clog2(RATIO + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(RATIO - 1);

  logic [WIDTH-1:0]       lanes [RATIO-1];
  logic [CNT_W-1:0]       fill;
  logic                   fp;
  logic [WIDTH*RATIO-1:0] data_q;
  logic [CNT_W-1:0]       count_q;
  logic                   valid_q;

  logic                   out_free;
  logic                   pop;
  logic                   flush_emit;
  logic [WIDTH*RATIO-1:0] full_beat;
  logic [WIDTH*RATIO-1:0] part_beat;

  always_comb begin
    out_free   = !valid_q || bus.ready_i;
    pop        = !rst_i && !bus.empty_i && !fp && !bus.flush_i && (fill < LAST || out_free);
    flush_emit = fp && out_free;
    full_beat  = '0;
    part_beat  = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      full_beat[k*WIDTH +: WIDTH] = lanes[k];
      if (CNT_W'(k) < fill) part_beat[k*WIDTH +: WIDTH] = lanes[k];
    end
    // The last lane never lives in the buffer: it comes straight from the FIFO head.
    full_beat[(RATIO-1)*WIDTH +: WIDTH] = bus.data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill    <= '0;
      fp      <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      for (int unsigned k = 0; k < RATIO - 1; k++) lanes[k] <= '0;
    end else begin
      if (valid_q && bus.ready_i) valid_q <= 1'b0;
      if (bus.flush_i && fill != '0) fp <= 1'b1;
      // A pending flush clears fp here, which also swallows a repeated flush_i.
      if (flush_emit) begin
        data_q  <= part_beat;
        count_q <= fill;
        valid_q <= 1'b1;
        fill    <= '0;
        fp      <= 1'b0;
      end else if (pop) begin
        if (fill < LAST) begin
          for (int unsigned k = 0; k < RATIO - 1; k++)
            if (CNT_W'(k) == fill) lanes[k] <= bus.data_i;
          fill <= fill + CNT_W'(1);
        end else begin
          data_q  <= full_beat;
          count_q <= CNT_W'(RATIO);
          valid_q <= 1'b1;
          fill    <= '0;
        end
      end
    end
  end

  assign bus.pop_o   = pop;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.count_o = count_q;
endmodule

// File: tb/tb_fifo_pop_packer.sv
// Bench for fifo_pop_packer: a FIFO model feeds words, expected beats go into a
// scoreboard queue and are compared as the packer hands them to the sink.
module tb_fifo_pop_packer;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned RATIO = 4;
  localparam int unsigned BW    = WIDTH * RATIO;

  typedef struct {
    logic [BW-1:0] data;
    logic [2:0]    count;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic ready;

  logic [WIDTH-1:0] fifo [$];
  beat_t            exp_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int pops  = 0;

  logic          s_pop;
  logic          s_valid;
  logic [BW-1:0] s_data;
  logic [2:0]    s_count;

  always #5 clk = ~clk;

  fifo_pop_packer_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

  fifo_pop_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [BW-1:0] d, input logic [2:0] c);
    beat_t b;
    b.data  = d;
    b.count = c;
    exp_q.push_back(b);
  endtask

  // One clock: drive inputs, sample on the falling edge, retire popped FIFO words after the rising edge.
  task automatic step();
    beat_t e;
    bus.flush_i = flush;
    bus.ready_i = ready;
    bus.empty_i = (fifo.size() == 0);
    bus.data_i  = (fifo.size() != 0) ? fifo[0] : '0;
    @(negedge clk);
    s_pop   = bus.pop_o;
    s_valid = bus.valid_o;
    s_data  = bus.data_o;
    s_count = bus.count_o;
    if (!rst && s_valid && ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_beat", s_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check_eq("beat_data", s_data, e.data);
        check_eq("beat_count", s_count, e.count);
      end
    end
    if (s_pop) begin
      pops++;
      if (fifo.size() == 0) check_eq("pop_when_empty", s_pop, 1'b0);
    end
    @(posedge clk);
    #1;
    if (s_pop && fifo.size() != 0) void'(fifo.pop_front());
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    ready = 1'b0;
    flush = 1'b0;
    step();

    // Reset held with a non-empty FIFO
    for (int i = 1; i <= 4; i++) fifo.push_back(32'hEE00 + 32'(i));
    repeat (2) begin
      step();
      check_eq("rst_pop", s_pop, 1'b0);
      check_eq("rst_valid", s_valid, 1'b0);
      check_eq("rst_data", s_data, '0);
      check_eq("rst_count", s_count, 3'd0);
    end
    fifo.delete();
    rst = 1'b0;
    step();
    check_eq("rel_pop", s_pop, 1'b0);
    check_eq("rel_valid", s_valid, 1'b0);
    check_eq("rel_data", s_data, '0);
    check_eq("rel_count", s_count, 3'd0);

    // Streaming
    pops  = 0;
    ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo.push_back(32'(i));
    push_beat(128'h00000004_00000003_00000002_00000001, 3'd4);
    push_beat(128'h00000008_00000007_00000006_00000005, 3'd4);
    run(8);
    check_eq("stream_pops", pops, 8);
    drain("stream_drain", 6);

    // Backpressure
    pops  = 0;
    ready = 1'b0;
    for (int i = 1; i <= 8; i++) fifo.push_back(32'(i));
    push_beat(128'h00000004_00000003_00000002_00000001, 3'd4);
    push_beat(128'h00000008_00000007_00000006_00000005, 3'd4);
    run(14);
    check_eq("bp_pops", pops, 7);
    check_eq("bp_pop_stall", s_pop, 1'b0);
    check_eq("bp_valid", s_valid, 1'b1);
    check_eq("bp_hold_data", s_data, 128'h00000004_00000003_00000002_00000001);
    ready = 1'b1;
    step();
    check_eq("bp_release_pop", s_pop, 1'b1);
    step();
    check_eq("bp_second_valid", s_valid, 1'b1);
    drain("bp_drain", 4);
    check_eq("bp_total_pops", pops, 8);

    // Flush of a partial beat
    pops  = 0;
    ready = 1'b1;
    for (int i = 1; i <= 7; i++) fifo.push_back(32'(i));
    push_beat(128'h00000000_00000003_00000002_00000001, 3'd3);
    push_beat(128'h00000007_00000006_00000005_00000004, 3'd4);
    run(3);
    flush = 1'b1;
    step();
    check_eq("flush_cycle_pop", s_pop, 1'b0);
    flush = 1'b0;
    step();
    check_eq("fp_pop", s_pop, 1'b0);
    check_eq("fp_valid", s_valid, 1'b0);
    step();
    check_eq("flush_latency", s_valid, 1'b1);
    drain("flush_drain", 10);
    check_eq("flush_pops", pops, 7);

    // Flush with nothing assembled
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("empty_flush_valid", s_valid, 1'b0);
    end

    // Flush behind a stalled full beat, flush_i repeated while pending
    ready = 1'b0;
    for (int i = 1; i <= 6; i++) fifo.push_back(32'h20 + 32'(i));
    push_beat(128'h00000024_00000023_00000022_00000021, 3'd4);
    push_beat(128'h00000000_00000000_00000026_00000025, 3'd2);
    run(6);
    flush = 1'b1;
    run(3);
    flush = 1'b0;
    run(2);
    check_eq("stall_hold_valid", s_valid, 1'b1);
    check_eq("stall_hold_count", s_count, 3'd4);
    ready = 1'b1;
    step();
    step();
    check_eq("stall_partial_valid", s_valid, 1'b1);
    run(4);
    drain("stall_drain", 4);

    // Reset while a full beat is stalled and two lanes are assembled
    ready = 1'b0;
    for (int i = 1; i <= 6; i++) fifo.push_back(32'h30 + 32'(i));
    run(6);
    check_eq("mid_stalled", s_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_eq("mid_rst_valid", s_valid, 1'b0);
    check_eq("mid_rst_count", s_count, 3'd0);
    for (int i = 10; i <= 13; i++) fifo.push_back(32'(i));
    push_beat(128'h0000000D_0000000C_0000000B_0000000A, 3'd4);
    ready = 1'b1;
    drain("mid_drain", 10);
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_pop_packer.md
# fifo_pop_packer

Downstream consumer for `fifo_v3`: pops narrow words from the FIFO's empty/pop interface and packs RATIO consecutive words into one wide beat on a valid/ready stream. It sits between a `fifo_v3` read port and a wide-datapath sink. It supports a flush that emits a partially filled beat with a lane count. The FIFO is used in non-fall-through mode, so `data_i` is valid whenever `empty_i` is low.

## Interface
Parameters:
- WIDTH, 32, width of one FIFO word
- RATIO, 4, words per output beat; legal range 2..16
- CNT_W, $clog2(RATIO+1), width of lane counters (derived, not overridden)

Ports:
- clk_i  in  1  clock; single clock domain, rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  request to emit the current partial beat
- empty_i  in  1  FIFO empty flag (connect to fifo `empty_o`)
- data_i  in  WIDTH  FIFO head word (connect to fifo `data_o`)
- pop_o  out  1  FIFO pop (connect to fifo `pop_i`)
- valid_o  out  1  output beat valid
- ready_i  in  1  sink ready
- data_o  out  WIDTH*RATIO  packed beat; lane k = data_o[k*WIDTH +: WIDTH]
- count_o  out  CNT_W  number of valid lanes in data_o (1..RATIO when valid_o is high)

## Operation
- Storage:
  - assembly buffer of RATIO-1 lanes plus fill counter `fill` (0..RATIO-1)
  - output register (data_o, count_o, valid_o)
  - flush-pending flag `fp`
- `out_free` = !valid_o || ready_i. The output register is empty or is being drained this cycle.
- `pop_o` = !rst_i && !empty_i && !fp && !flush_i && (fill < RATIO-1 || out_free).
- On each pop:
  - if fill < RATIO-1: lane[fill] <= data_i; fill++.
  - if fill == RATIO-1: the output register loads {data_i, lanes[RATIO-2:0]}; count_o <= RATIO; valid_o <= 1; fill <= 0.
- Lane order: the first popped word goes to lane 0 (LSBs).
- Handshake:
  - the beat transfers on valid_o && ready_i
  - if no new beat loads in the same cycle, valid_o <= 0
  - data_o and count_o are held stable while valid_o && !ready_i
- Flush:
  - flush_i high with fill == 0 and fp == 0: no-op.
  - flush_i high with fill > 0: sets fp.
  - While fp is set and out_free: the output register loads the assembly lanes with unused lanes zeroed; count_o <= fill; valid_o <= 1; fill <= 0; fp <= 0.
  - The partial emit is decided from the registered fp, so it occurs no earlier than the cycle after flush_i.
  - pop_o is 0 on the flush_i cycle and while fp is set. No word is popped into a beat being flushed.
- flush_i while fp is already set: ignored, with no double emit.
- Reset (rst_i high at a clock edge):
  - valid_o=0, data_o=0, count_o=0, fill=0, fp=0, assembly lanes=0
  - pop_o is 0 combinationally while rst_i is high
  - reset mid-beat discards partial lanes and any undelivered output beat

## Timing
- pop_o is combinational from empty_i, ready_i, flush_i and state. There is no combinational path from data_i to any output.
- valid_o, data_o and count_o are registered.
- Latency: the RATIO-th pop at edge t gives valid_o=1 after edge t, visible in cycle t+1.
- Throughput: with empty_i=0 and ready_i=1 steady, one pop per cycle and one beat every RATIO cycles, with no bubbles. This includes the cycle where the full beat loads while the previous beat drains.
- Backpressure: with valid_o=1, ready_i=0 and fill == RATIO-1, pop_o=0 until ready_i rises. In that same cycle pop_o=1 and the new beat replaces the drained one.
- Flush latency: flush_i at cycle n with out_free gives the partial beat valid in cycle n+2. With the output register busy, the partial beat is emitted on the cycle after the busy beat transfers.

## Test plan
All scenarios use WIDTH=32, RATIO=4.
- Reset: hold rst_i for 2 cycles with FIFO non-empty -> pop_o=0, valid_o=0, data_o=0, count_o=0 throughout and on the first cycle after release.
- Streaming: FIFO supplies 1..8 (as in the existing FIFO bench counter pattern), ready_i=1 -> beats data_o=0x00000004_00000003_00000002_00000001 then 0x…08_07_06_05, count_o=4, one pop per cycle, 8 pops in 8 cycles.
- Backpressure: ready_i=0 for 10 cycles after the first beat -> exactly 3 further pops, then pop_o=0; first beat held unchanged; after ready_i rises, second beat 5..8 follows next cycle.
- Flush partial: pop 1,2,3, then assert flush_i for one cycle -> beat 0x00000000_00000003_00000002_00000001, count_o=3; no pop on flush cycle; next beat starts at lane 0 with word 4.
- Flush corner cases: flush_i with fill=0 -> no beat emitted. flush_i while a full beat is stalled (ready_i=0) with fill=2 -> partial count_o=2 follows the stalled beat. Repeated flush_i while fp is set -> single partial beat.
- Reset mid-operation: rst_i after 2 pops with valid_o=1 stalled -> valid_o=0 next cycle; following pops 10,11,12,13 give beat 0x0000000D_0000000C_0000000B_0000000A.
